// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Fetch-side initiator for the instruction memory. It owns the PC, issues
// word-addressed requests, and captures returned instructions into a
// one-entry output register that decode drains with a ready/valid handshake.
// It also applies PC redirects from branch/jump resolution and watches for
// requests the memory never answers.
//
// Parameters:
//   RESET_PC : byte PC loaded on reset (4-byte aligned)
//   TIMEOUT  : unanswered requesting cycles before the error state (0 = off)
//   CNT_W    : timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active LOW
//   fetch_req        out  request to instruction memory
//   fetch_addr       out  word address {2'b00, pc[31:2]}
//   request_data     in   instruction returned by memory
//   fetch_data_valid in   request_data is valid for fetch_addr
//   inst             out  captured instruction for decode
//   inst_pc          out  byte PC of inst
//   inst_valid       out  inst/inst_pc valid
//   inst_ready       in   decode accepts inst this cycle
//   redirect         in   load redirect_pc and flush
//   redirect_pc      in   redirect byte target
//   pc               out  current fetch PC (byte address)
//   fetch_err        out  sticky error (timeout or misaligned redirect)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic [31:0] request_data,
    input  logic        fetch_data_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

    state_t             state_reg,      state_next;
    logic [31:0]        pc_reg,         pc_next;
    logic [31:0]        inst_reg,       inst_next;
    logic [31:0]        inst_pc_reg,    inst_pc_next;
    logic               inst_valid_reg, inst_valid_next;
    logic [CNT_W-1:0]   cnt_reg,        cnt_next;
    logic [CNT_W-1:0]   cnt_inc;

    // A request goes out only when the output slot is free or being drained
    // this cycle, so a stalled decode never has data dropped on the floor.
    assign fetch_req  = (state_reg == S_FETCH) && (!inst_valid_reg || inst_ready);
    assign fetch_addr = {2'b00, pc_reg[31:2]};
    assign pc         = pc_reg;
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign inst_valid = inst_valid_reg;
    assign fetch_err  = (state_reg == S_ERR);

    assign cnt_inc    = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_valid_next = inst_valid_reg;
        cnt_next        = cnt_reg;

        if (state_reg != S_ERR && redirect) begin
            // Redirect beats everything, including a same-cycle response and
            // a timeout expiring on this edge: the in-flight fetch is dead.
            inst_valid_next = 1'b0;
            cnt_next        = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_next = S_ERR;
            end else begin
                pc_next    = redirect_pc;
                state_next = S_FETCH;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_req && fetch_data_valid) begin
                        // Capture wins over a same-cycle consume: the slot is
                        // simply refilled with the new instruction.
                        inst_next       = request_data;
                        inst_pc_next    = pc_reg;
                        inst_valid_next = 1'b1;
                        pc_next         = pc_reg + 32'd4;
                        cnt_next        = '0;
                    end else begin
                        if (inst_valid_reg && inst_ready) begin
                            inst_valid_next = 1'b0;
                        end
                        if (fetch_req) begin
                            cnt_next = cnt_inc;
                            if (TIMEOUT_EN && cnt_inc == TIMEOUT_CNT) begin
                                state_next      = S_ERR;
                                inst_valid_next = 1'b0;
                            end
                        end
                    end
                end
                S_ERR: begin
                    inst_valid_next = 1'b0;
                end
                default: begin
                    state_next      = S_ERR;
                    inst_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            inst_valid_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= inst_valid_next;
            cnt_reg        <= cnt_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. Main instance: RESET_PC=0, TIMEOUT=4. A second
// instance with RESET_PC=FFFF_FFF8 exercises PC wrap-around. Memory is
// combinational: data is a fixed function of the word address.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] MAIN_RPC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RPC = 32'hFFFF_FFF8;
    localparam int          TO       = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- main DUT signals ----------------
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] request_data;
    logic        fetch_data_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        fetch_err;

    // ---------------- wrap DUT signals ----------------
    logic        rst_w;
    logic        fetch_req_w;
    logic [31:0] fetch_addr_w;
    logic [31:0] request_data_w;
    logic        fetch_data_valid_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic        inst_valid_w;
    logic        inst_ready_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic [31:0] pc_w;
    logic        fetch_err_w;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return 32'h1000_0000 + (wa * 32'd17) ^ (wa << 20);
    endfunction

    assign request_data   = mem_word(fetch_addr);
    assign request_data_w = mem_word(fetch_addr_w);

    inst_fetch #(.RESET_PC(MAIN_RPC), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .request_data     (request_data),
        .fetch_data_valid (fetch_data_valid),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .pc               (pc),
        .fetch_err        (fetch_err)
    );

    inst_fetch #(.RESET_PC(WRAP_RPC), .TIMEOUT(16), .CNT_W(8)) dut_w (
        .clk              (clk),
        .rst              (rst_w),
        .fetch_req        (fetch_req_w),
        .fetch_addr       (fetch_addr_w),
        .request_data     (request_data_w),
        .fetch_data_valid (fetch_data_valid_w),
        .inst             (inst_w),
        .inst_pc          (inst_pc_w),
        .inst_valid       (inst_valid_w),
        .inst_ready       (inst_ready_w),
        .redirect         (redirect_w),
        .redirect_pc      (redirect_pc_w),
        .pc               (pc_w),
        .fetch_err        (fetch_err_w)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle, the combinational outputs seen
    // during that cycle, and the registered outputs after its clock edge.
    typedef struct {
        logic        ready;
        logic        fdv;
        logic        red;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst_pc;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic ready, input logic fdv, input logic red,
                                input logic [31:0] rpc, input logic exp_req,
                                input logic [31:0] exp_addr, input logic exp_valid,
                                input logic [31:0] exp_inst_pc, input logic [31:0] exp_pc,
                                input logic exp_err);
        vec_t v;
        v.ready = ready;  v.fdv = fdv;  v.red = red;  v.rpc = rpc;
        v.exp_req = exp_req;  v.exp_addr = exp_addr;  v.exp_valid = exp_valid;
        v.exp_inst_pc = exp_inst_pc;  v.exp_pc = exp_pc;  v.exp_err = exp_err;
        return v;
    endfunction

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic set_in(input logic rdy, input logic fdv, input logic red, input logic [31:0] rpc);
        inst_ready       = rdy;
        fetch_data_valid = fdv;
        redirect         = red;
        redirect_pc      = rpc;
    endtask

    // Enter reset away from a clock edge, hold it over two edges, release on
    // a falling edge. Leaves the DUT in its idle state.
    task automatic do_reset();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference model state for the random phase.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_err;
    int          m_miss;
    logic [31:0] exp_acc;
    logic        m_req;
    int          n_acc;

    initial begin
        rst = 1'b0;
        rst_w = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        inst_ready_w       = 1'b1;
        fetch_data_valid_w = 1'b1;
        redirect_w         = 1'b0;
        redirect_pc_w      = 32'h0;

        //                 rdy fdv red rpc         req addr      vld ipc         pc          err
        vecs[0]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h0,  0); // idle -> fetch
        vecs[1]  = mk(1, 1, 0, 32'h0,  1, 32'h0,  1, 32'h0,  32'h4,  0); // first capture, 2nd edge
        vecs[2]  = mk(1, 1, 0, 32'h0,  1, 32'h1,  1, 32'h4,  32'h8,  0);
        vecs[3]  = mk(1, 1, 0, 32'h0,  1, 32'h2,  1, 32'h8,  32'hC,  0);
        vecs[4]  = mk(0, 1, 0, 32'h0,  0, 32'h3,  1, 32'h8,  32'hC,  0); // stall
        vecs[5]  = mk(0, 1, 0, 32'h0,  0, 32'h3,  1, 32'h8,  32'hC,  0);
        vecs[6]  = mk(0, 1, 0, 32'h0,  0, 32'h3,  1, 32'h8,  32'hC,  0);
        vecs[7]  = mk(1, 1, 0, 32'h0,  1, 32'h3,  1, 32'hC,  32'h10, 0); // release, no gap
        vecs[8]  = mk(1, 1, 1, 32'h30, 1, 32'h4,  0, 32'h0,  32'h30, 0); // redirect drops data
        vecs[9]  = mk(1, 1, 0, 32'h0,  1, 32'hC,  1, 32'h30, 32'h34, 0);
        vecs[10] = mk(1, 0, 0, 32'h0,  1, 32'hD,  0, 32'h0,  32'h34, 0); // consume only
        vecs[11] = mk(0, 0, 0, 32'h0,  1, 32'hD,  0, 32'h0,  32'h34, 0); // empty slot still requests
        vecs[12] = mk(1, 1, 0, 32'h0,  1, 32'hD,  1, 32'h34, 32'h38, 0);
        vecs[13] = mk(1, 0, 0, 32'h0,  1, 32'hE,  0, 32'h0,  32'h38, 0); // miss 1
        vecs[14] = mk(1, 0, 0, 32'h0,  1, 32'hE,  0, 32'h0,  32'h38, 0); // miss 2
        vecs[15] = mk(1, 0, 0, 32'h0,  1, 32'hE,  0, 32'h0,  32'h38, 0); // miss 3
        vecs[16] = mk(1, 0, 1, 32'h80, 1, 32'hE,  0, 32'h0,  32'h80, 0); // redirect on 4th edge wins
        vecs[17] = mk(1, 0, 0, 32'h0,  1, 32'h20, 0, 32'h0,  32'h80, 0);
        vecs[18] = mk(1, 0, 0, 32'h0,  1, 32'h20, 0, 32'h0,  32'h80, 0);
        vecs[19] = mk(1, 0, 0, 32'h0,  1, 32'h20, 0, 32'h0,  32'h80, 0);
        vecs[20] = mk(1, 0, 0, 32'h0,  1, 32'h20, 0, 32'h0,  32'h80, 1); // 4th miss -> error
        vecs[21] = mk(1, 1, 1, 32'h8,  0, 32'h20, 0, 32'h0,  32'h80, 1); // ignored in error
        vecs[22] = mk(1, 1, 0, 32'h0,  0, 32'h20, 0, 32'h0,  32'h80, 1);

        // ---------------- reset values ----------------
        #2;
        chk32("rst_pc", pc, MAIN_RPC);
        chk1 ("rst_valid", inst_valid, 1'b0);
        chk1 ("rst_req", fetch_req, 1'b0);
        chk1 ("rst_err", fetch_err, 1'b0);
        chk32("rst_addr", fetch_addr, {2'b00, MAIN_RPC[31:2]});
        chk32("rst_inst", inst, 32'h0);
        chk32("rst_inst_pc", inst_pc, 32'h0);

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            set_in(vecs[i].ready, vecs[i].fdv, vecs[i].red, vecs[i].rpc);
            #1;
            chk1 ("vec_req", fetch_req, vecs[i].exp_req);
            chk32("vec_addr", fetch_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            chk1 ("vec_valid", inst_valid, vecs[i].exp_valid);
            chk32("vec_pc", pc, vecs[i].exp_pc);
            chk1 ("vec_err", fetch_err, vecs[i].exp_err);
            if (vecs[i].exp_valid) begin
                chk32("vec_inst_pc", inst_pc, vecs[i].exp_inst_pc);
                chk32("vec_inst", inst, mem_word({2'b00, vecs[i].exp_inst_pc[31:2]}));
            end
            $display("vec %0d: valid=%b inst_pc=%h pc=%h err=%b", i, inst_valid, inst_pc, pc, fetch_err);
        end

        // ---------------- misaligned redirect ----------------
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;                       // idle -> fetch
        @(posedge clk); #1;                       // capture word 0
        chk1 ("mis_pre_valid", inst_valid, 1'b1);
        set_in(1'b1, 1'b1, 1'b1, 32'h6);
        @(posedge clk); #1;
        chk1 ("mis_err", fetch_err, 1'b1);
        chk1 ("mis_valid", inst_valid, 1'b0);
        chk32("mis_pc_held", pc, 32'h4);
        set_in(1'b1, 1'b1, 1'b1, 32'h8);
        repeat (3) begin
            #1;
            chk1 ("mis_req_off", fetch_req, 1'b0);
            @(posedge clk); #1;
            chk1 ("mis_err_sticky", fetch_err, 1'b1);
            chk32("mis_redirect_ignored", pc, 32'h4);
        end
        $display("misaligned redirect: err=%b pc=%h", fetch_err, pc);
        // Asynchronous reset mid-cycle clears everything without an edge.
        #2;
        rst = 1'b0;
        #1;
        chk1 ("arst_err", fetch_err, 1'b0);
        chk32("arst_pc", pc, MAIN_RPC);
        chk1 ("arst_valid", inst_valid, 1'b0);
        chk1 ("arst_req", fetch_req, 1'b0);
        chk32("arst_inst", inst, 32'h0);

        // ---------------- randomized vs. reference model ----------------
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        m_pc = MAIN_RPC; m_valid = 1'b0; m_err = 1'b0; m_miss = 0; exp_acc = MAIN_RPC;
        n_acc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15) == 0, {24'h0, 2'b00, $urandom_range(0, 63) % 64 == 0 ? 6'd0 : 6'($urandom_range(0, 63))} << 2);
            #1;
            m_req = !m_err && (!m_valid || inst_ready);
            chk1 ("rnd_req", fetch_req, m_req);
            chk32("rnd_addr", fetch_addr, {2'b00, m_pc[31:2]});
            // Ordered-stream scoreboard: each instruction decode accepts must
            // be the next sequential one since reset or the last redirect.
            if (!m_err && !redirect && m_valid && inst_ready) begin
                chk32("rnd_acc_pc", inst_pc, exp_acc);
                chk32("rnd_acc_inst", inst, mem_word({2'b00, exp_acc[31:2]}));
                $display("accept %0d: inst_pc=%h inst=%h", n_acc, inst_pc, inst);
                n_acc++;
                exp_acc = exp_acc + 32'd4;
            end
            if (!m_err) begin
                if (redirect) begin
                    m_valid = 1'b0;
                    m_miss = 0;
                    m_pc = redirect_pc;
                    exp_acc = redirect_pc;
                end else if (m_req && fetch_data_valid) begin
                    m_valid = 1'b1;
                    m_pc = m_pc + 32'd4;
                    m_miss = 0;
                end else begin
                    if (m_valid && inst_ready) m_valid = 1'b0;
                    if (m_req) begin
                        m_miss++;
                        if (m_miss == TO) begin
                            m_err = 1'b1;
                            m_valid = 1'b0;
                        end
                    end
                end
            end
            @(posedge clk); #1;
            chk1 ("rnd_valid", inst_valid, m_valid);
            chk32("rnd_pc", pc, m_pc);
            chk1 ("rnd_err", fetch_err, m_err);
            if (m_err) begin
                $display("random: timeout error at cycle %0d, restarting", cyc);
                do_reset();
                set_in(1'b0, 1'b0, 1'b0, 32'h0);
                @(posedge clk); #1;
                m_pc = MAIN_RPC; m_valid = 1'b0; m_err = 1'b0; m_miss = 0; exp_acc = MAIN_RPC;
            end
        end

        // ---------------- PC wrap on second instance ----------------
        @(negedge clk);
        rst_w = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk1("wrap_err", fetch_err_w, 1'b0);
            if (k >= 2) begin
                logic [31:0] want;
                want = WRAP_RPC + 32'(4 * (k - 2));
                chk1 ("wrap_valid", inst_valid_w, 1'b1);
                chk32("wrap_inst_pc", inst_pc_w, want);
                chk32("wrap_inst", inst_w, mem_word({2'b00, want[31:2]}));
                chk32("wrap_pc", pc_w, want + 32'd4);
                $display("wrap capture: inst_pc=%h pc=%h", inst_pc_w, pc_w);
            end
        end
        #2;
        rst_w = 1'b0;
        #1;
        chk1 ("wrap_arst_valid", inst_valid_w, 1'b0);
        chk32("wrap_arst_pc", pc_w, WRAP_RPC);
        chk32("wrap_arst_addr", fetch_addr_w, 32'h3FFF_FFFE);
        chk1 ("wrap_arst_req", fetch_req_w, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
